rk_coef_bank: RTL and testbench

//  Double-buffered register bank for Runge-Kutta solver parameters: Butcher tableau a/b/c,

---
 rtl/rk_bank_pkg.sv | 16 +
 rtl/rk_shadow_bank.sv | 25 ++
 rtl/rk_coef_bank.sv | 92 +++++++++
 tb/tb_rk_coef_bank.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rk_bank_pkg.sv
// rk_bank_pkg: bank FSM states and RK tableau layout helpers
package rk_bank_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, PEND, SWAP} state_t;
  function automatic int b_base(int s);
    return s * s;
  endfunction
  function automatic int c_base(int s);
    return s * s + s;
  endfunction
  function automatic int k_base(int s);
    return s * s + 2 * s;
  endfunction
  function automatic int nent(int s);
    return s * s + 3 * s + 3;
  endfunction
endpackage

// File: rtl/rk_shadow_bank.sv
// rk_shadow_bank: host-written shadow register file with sticky out-of-range error
module rk_shadow_bank #(
  parameter int WIDTH = 32,
  parameter int NENT = 21,
  parameter int AW = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [AW-1:0]           addr,
  input  logic signed [WIDTH-1:0] data,
  output logic signed [WIDTH-1:0] mem [NENT],
  output logic                    err
);
  logic in_range;
  assign in_range = {1'b0, addr} < (AW + 1)'(NENT);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NENT; i++) mem[i] <= '0;
      err <= 1'b0;
    end else if (we) begin
      if (in_range) mem[addr] <= data;
      else err <= 1'b1;
    end
endmodule

// File: rtl/rk_coef_bank.sv
// rk_coef_bank: double-buffered RK parameter bank with guarded promotion and step advance
module rk_coef_bank
  import rk_bank_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int S = 3,
  localparam int NENT = nent(S),
  localparam int AW = $clog2(NENT)
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  input  logic [AW-1:0]           i_wr_addr,
  input  logic signed [WIDTH-1:0] i_wr_data,
  input  logic                    i_commit,
  input  logic                    i_busy,
  input  logic                    i_step_done,
  input  logic signed [WIDTH-1:0] i_y_next,
  output logic signed [WIDTH-1:0] o_a [S*S],
  output logic signed [WIDTH-1:0] o_b [S],
  output logic signed [WIDTH-1:0] o_c [S],
  output logic signed [WIDTH-1:0] o_k [S],
  output logic signed [WIDTH-1:0] o_x0,
  output logic signed [WIDTH-1:0] o_y0,
  output logic signed [WIDTH-1:0] o_h0,
  output logic                    o_valid,
  output logic                    o_swap_done,
  output logic                    o_err,
  output logic [15:0]             o_step_cnt
);
  localparam int XI = NENT - 3;
  localparam int YI = NENT - 2;
  localparam int HI = NENT - 1;
  localparam int KB = k_base(S);
  state_t state, state_n;
  logic wr_acc, step_ok;
  logic signed [WIDTH-1:0] shd [NENT];
  logic signed [WIDTH-1:0] act [NENT];
  rk_shadow_bank #(.WIDTH(WIDTH), .NENT(NENT), .AW(AW)) u_shadow (
    .clk(clk),
    .rst(i_rst),
    .we(wr_acc),
    .addr(i_wr_addr),
    .data(i_wr_data),
    .mem(shd),
    .err(o_err)
  );
  always_ff @(posedge clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == PEND ? (i_busy ? PEND : SWAP) :
              state == SWAP ? IDLE :
              i_commit ? (i_busy ? PEND : SWAP) :
              wr_acc ? LOAD : state;
  always_comb begin
    o_wr_ready = state == IDLE || state == LOAD;
    wr_acc = i_wr_valid && o_wr_ready;
    step_ok = i_step_done && o_valid && state != SWAP;
  end
  always_ff @(posedge clk or posedge i_rst)
    if (i_rst) begin
      for (int i = 0; i < NENT; i++) act[i] <= '0;
      o_valid <= 1'b0;
      o_step_cnt <= '0;
      o_swap_done <= 1'b0;
    end else begin
      o_swap_done <= state == SWAP;
      if (state == SWAP) begin
        act <= shd;
        o_valid <= 1'b1;
        o_step_cnt <= '0;
      end else if (step_ok) begin
        act[XI] <= act[XI] + act[HI];
        act[YI] <= i_y_next;
        for (int i = 0; i < S; i++) act[KB+i] <= '0;
        o_step_cnt <= o_step_cnt + 16'(~&o_step_cnt);
      end
    end
  for (genvar i = 0; i < S * S; i++) begin : g_a
    assign o_a[i] = act[i];
  end
  for (genvar j = 0; j < S; j++) begin : g_bck
    assign o_b[j] = act[b_base(S)+j];
    assign o_c[j] = act[c_base(S)+j];
    assign o_k[j] = act[KB+j];
  end
  assign o_x0 = act[XI];
  assign o_y0 = act[YI];
  assign o_h0 = act[HI];
endmodule

// File: tb/tb_rk_coef_bank.sv
// tb_rk_coef_bank: randomized self-checking bench against a transaction-level bank model
module tb_rk_coef_bank;
  localparam int W = 32;
  localparam int N = 21;
  logic clk = 1'b0, i_rst = 1'b0, i_wr_valid = 1'b0, i_commit = 1'b0, i_busy = 1'b0, i_step_done = 1'b0;
  logic [4:0] i_wr_addr = '0;
  logic signed [W-1:0] i_wr_data = '0, i_y_next = '0;
  logic o_wr_ready, o_valid, o_swap_done, o_err;
  logic [15:0] o_step_cnt;
  logic signed [W-1:0] o_a [9];
  logic signed [W-1:0] o_b [3];
  logic signed [W-1:0] o_c [3];
  logic signed [W-1:0] o_k [3];
  logic signed [W-1:0] o_x0, o_y0, o_h0;
  logic signed [W-1:0] m_shd [N];
  logic signed [W-1:0] m_act [N];
  bit m_valid, m_err;
  int m_cnt;
  int checks = 0, errors = 0;
  rk_coef_bank #(.WIDTH(W), .S(3)) dut (
    .clk(clk), .i_rst(i_rst), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_commit(i_commit), .i_busy(i_busy),
    .i_step_done(i_step_done), .i_y_next(i_y_next), .o_a(o_a), .o_b(o_b), .o_c(o_c),
    .o_k(o_k), .o_x0(o_x0), .o_y0(o_y0), .o_h0(o_h0), .o_valid(o_valid),
    .o_swap_done(o_swap_done), .o_err(o_err), .o_step_cnt(o_step_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic signed [W-1:0] dut_ent(int i);
    if (i < 9) return o_a[i];
    if (i < 12) return o_b[i-9];
    if (i < 15) return o_c[i-12];
    if (i < 18) return o_k[i-15];
    if (i == 18) return o_x0;
    if (i == 19) return o_y0;
    return o_h0;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_shd[i] = '0;
      m_act[i] = '0;
    end
    m_valid = 0;
    m_err = 0;
    m_cnt = 0;
  endtask
  task automatic wr(input int addr, input logic signed [W-1:0] data);
    i_wr_valid = 1'b1;
    i_wr_addr = 5'(addr);
    i_wr_data = data;
    tick();
    i_wr_valid = 1'b0;
    if (addr < N) m_shd[addr] = data;
    else m_err = 1;
  endtask
  task automatic commit_idle();
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
    tick();
    m_act = m_shd;
    m_valid = 1;
    m_cnt = 0;
  endtask
  task automatic step(input logic signed [W-1:0] y);
    i_step_done = 1'b1;
    i_y_next = y;
    tick();
    i_step_done = 1'b0;
    if (m_valid) begin
      m_act[18] = m_act[18] + m_act[20];
      m_act[19] = y;
      for (int i = 15; i < 18; i++) m_act[i] = '0;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask
  task automatic test_reset();
    i_rst = 1'b1;
    model_reset();
    #2;
    @(negedge clk);
    i_rst = 1'b0;
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_err !== 1'b0 || o_swap_done !== 1'b0 || o_step_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b err=%b swap=%b cnt=%0d expected 0 0 0 0", o_valid, o_err, o_swap_done, o_step_cnt);
    end
    checks++;
    if (o_wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", o_wr_ready);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (dut_ent(i) !== 0) begin
        errors++;
        $display("FAIL reset_entry[%0d]: got %0d expected 0", i, dut_ent(i));
      end
    end
  endtask
  task automatic test_load_commit();
    for (int i = 0; i < N; i++) wr(i, i + 1);
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_swap_done !== 1'b0 || o_h0 !== 0) begin
      errors++;
      $display("FAIL load_early: valid=%b swap=%b h0=%0d expected 0 0 0", o_valid, o_swap_done, o_h0);
    end
    tick();
    m_act = m_shd;
    m_valid = 1;
    m_cnt = 0;
    checks++;
    if (o_a[0] !== 1 || o_h0 !== 21 || o_valid !== 1'b1 || o_swap_done !== 1'b1) begin
      errors++;
      $display("FAIL load_commit: a0=%0d h0=%0d valid=%b swap=%b expected 1 21 1 1", o_a[0], o_h0, o_valid, o_swap_done);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (dut_ent(i) !== m_act[i]) begin
        errors++;
        $display("FAIL load_entry[%0d]: got %0d expected %0d", i, dut_ent(i), m_act[i]);
      end
    end
    tick();
    checks++;
    if (o_swap_done !== 1'b0) begin
      errors++;
      $display("FAIL load_swap_pulse: got %b expected 0", o_swap_done);
    end
  endtask
  task automatic test_busy_commit();
    for (int n = 0; n < 4; n++) wr($urandom_range(0, N - 1), $urandom);
    i_busy = 1'b1;
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (o_wr_ready !== 1'b0 || o_swap_done !== 1'b0) begin
        errors++;
        $display("FAIL busy_hold[%0d]: ready=%b swap=%b expected 0 0", c, o_wr_ready, o_swap_done);
      end
      i_wr_valid = 1'b1;
      i_wr_addr = 5'd0;
      i_wr_data = 32'h5a5a_5a5a;
      i_commit = c == 2;
      tick();
      i_wr_valid = 1'b0;
      i_commit = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (dut_ent(i) !== m_act[i]) begin
        errors++;
        $display("FAIL busy_unchanged[%0d]: got %0d expected %0d", i, dut_ent(i), m_act[i]);
      end
    end
    i_busy = 1'b0;
    tick();
    checks++;
    if (o_h0 !== m_act[20] || o_swap_done !== 1'b0) begin
      errors++;
      $display("FAIL busy_release_early: h0=%0d swap=%b expected %0d 0", o_h0, o_swap_done, m_act[20]);
    end
    tick();
    m_act = m_shd;
    m_cnt = 0;
    checks++;
    if (o_swap_done !== 1'b1 || o_wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_swap: swap=%b ready=%b expected 1 1", o_swap_done, o_wr_ready);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (dut_ent(i) !== m_act[i]) begin
        errors++;
        $display("FAIL busy_promote[%0d]: got %0d expected %0d", i, dut_ent(i), m_act[i]);
      end
    end
  endtask
  task automatic test_bad_addr();
    wr(21, 32'hdead_beef);
    checks++;
    if (o_err !== 1'b1) begin
      errors++;
      $display("FAIL bad_addr_err: got %b expected 1", o_err);
    end
    wr($urandom_range(22, 31), $urandom);
    wr(7, $urandom);
    commit_idle();
    checks++;
    if (o_err !== 1'b1) begin
      errors++;
      $display("FAIL bad_addr_sticky: got %b expected 1", o_err);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (dut_ent(i) !== m_act[i]) begin
        errors++;
        $display("FAIL bad_addr_entry[%0d]: got %0d expected %0d", i, dut_ent(i), m_act[i]);
      end
    end
  endtask
  task automatic test_step();
    wr(18, 10);
    wr(20, 3);
    for (int i = 15; i < 18; i++) wr(i, $urandom);
    commit_idle();
    step(7);
    step(8);
    step(9);
    checks++;
    if (o_x0 !== 19 || o_y0 !== 9 || o_step_cnt !== 16'd3) begin
      errors++;
      $display("FAIL step_fixed: x0=%0d y0=%0d cnt=%0d expected 19 9 3", o_x0, o_y0, o_step_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_k[i] !== 0) begin
        errors++;
        $display("FAIL step_k[%0d]: got %0d expected 0", i, o_k[i]);
      end
    end
    wr(18, $urandom);
    wr(20, $urandom);
    commit_idle();
    for (int n = 0, lim = $urandom_range(2, 6); n < lim; n++) step($urandom);
    checks++;
    if (o_step_cnt !== 16'(m_cnt)) begin
      errors++;
      $display("FAIL step_cnt: got %0d expected %0d", o_step_cnt, m_cnt);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (dut_ent(i) !== m_act[i]) begin
        errors++;
        $display("FAIL step_entry[%0d]: got %0d expected %0d", i, dut_ent(i), m_act[i]);
      end
    end
    commit_idle();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (dut_ent(i) !== m_shd[i]) begin
        errors++;
        $display("FAIL step_shadow_kept[%0d]: got %0d expected %0d", i, dut_ent(i), m_shd[i]);
      end
    end
  endtask
  task automatic test_step_on_swap();
    step(123);
    for (int n = 0; n < 5; n++) wr($urandom_range(0, N - 1), $urandom);
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
    i_step_done = 1'b1;
    i_y_next = $urandom;
    tick();
    i_step_done = 1'b0;
    m_act = m_shd;
    m_cnt = 0;
    checks++;
    if (o_step_cnt !== 16'd0 || o_swap_done !== 1'b1) begin
      errors++;
      $display("FAIL swap_step_cnt: cnt=%0d swap=%b expected 0 1", o_step_cnt, o_swap_done);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (dut_ent(i) !== m_act[i]) begin
        errors++;
        $display("FAIL swap_step_entry[%0d]: got %0d expected %0d", i, dut_ent(i), m_act[i]);
      end
    end
  endtask
  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: wr($urandom_range(0, N - 1), $urandom);
        1: step($urandom);
        2: commit_idle();
        default: begin
          automatic int a = $urandom_range(0, N - 1);
          automatic logic signed [W-1:0] d = $urandom;
          i_wr_valid = 1'b1;
          i_wr_addr = 5'(a);
          i_wr_data = d;
          i_commit = 1'b1;
          tick();
          i_wr_valid = 1'b0;
          i_commit = 1'b0;
          tick();
          m_shd[a] = d;
          m_act = m_shd;
          m_cnt = 0;
        end
      endcase
      checks++;
      if (o_valid !== m_valid || o_err !== m_err || o_step_cnt !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL b2b_flags[%0d]: valid=%b err=%b cnt=%0d expected %b %b %0d", n, o_valid, o_err, o_step_cnt, m_valid, m_err, m_cnt);
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (dut_ent(i) !== m_act[i]) begin
          errors++;
          $display("FAIL b2b_entry[%0d][%0d]: got %0d expected %0d", n, i, dut_ent(i), m_act[i]);
        end
      end
    end
  endtask
  task automatic test_reset_pend();
    wr(20, $urandom);
    i_busy = 1'b1;
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
    tick();
    tick();
    #2;
    i_rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_err !== 1'b0 || o_h0 !== 0 || o_step_cnt !== 16'd0) begin
      errors++;
      $display("FAIL pend_reset: valid=%b err=%b h0=%0d cnt=%0d expected 0 0 0 0", o_valid, o_err, o_h0, o_step_cnt);
    end
    @(negedge clk);
    i_rst = 1'b0;
    i_busy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (o_swap_done !== 1'b0 || o_valid !== 1'b0 || o_wr_ready !== 1'b1) begin
        errors++;
        $display("FAIL pend_no_swap[%0d]: swap=%b valid=%b ready=%b expected 0 0 1", c, o_swap_done, o_valid, o_wr_ready);
      end
    end
    step(55);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (dut_ent(i) !== 0) begin
        errors++;
        $display("FAIL pend_entry[%0d]: got %0d expected 0", i, dut_ent(i));
      end
    end
    checks++;
    if (o_step_cnt !== 16'd0) begin
      errors++;
      $display("FAIL pend_step_ignored: cnt=%0d expected 0", o_step_cnt);
    end
  endtask
  initial begin
    test_reset();
    test_load_commit();
    test_busy_commit();
    test_bad_addr();
    test_step();
    test_step_on_swap();
    test_back_to_back();
    test_reset_pend();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
